// File: rtl/qam_pkg.sv
// Shared constants, quadrant encoding, sign convention and the quarter-wave
// LUT generator for the QPSK/4-QAM carrier modulator.
package qam_pkg;

  localparam int PHASE_W_DEF    = 16;
  localparam int LUT_AW_DEF     = 6;
  localparam int AMP_W_DEF      = 10;
  localparam int SYMBOL_LEN_DEF = 16;
  localparam int PHASE_INC_DEF  = 8192;

  // Sign bits arriving from the serial-to-parallel stage: 1 means negative.
  localparam logic SIGN_NEG = 1'b1;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_t;

  typedef struct packed {
    logic s_sin;
    logic s_cos;
  } sign_pair_t;

  function automatic int amax(input int amp_w);
    return (1 << (amp_w - 1)) - 1;
  endfunction

  // Quadrants 1 and 3 walk the quarter table backwards.
  function automatic logic quad_mirrors(input quadrant_t q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // The lower half of the circle is the negated upper half.
  function automatic logic quad_negates(input quadrant_t q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // round(AMAX * sin(pi/2 * k / 2^lut_aw)), evaluated at elaboration with a
  // Q30 Taylor series so no real arithmetic reaches synthesis.
  function automatic int quarter_sine(input int k, input int lut_aw, input int amp_w);
    longint x;
    longint term;
    longint sum;
    longint res;
    longint peak;
    peak = longint'(amax(amp_w));
    x    = (64'sd1686629713 * longint'(k)) >>> lut_aw;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    res = (peak * sum + (64'sd1 <<< 29)) >>> 30;
    if (res > peak) res = peak;
    if (res < 0)    res = 0;
    return int'(res);
  endfunction

endpackage

// File: rtl/qam_modulator_if.sv
// Symbol-sign input and modulated-sample output bundle of qam_modulator.
interface qam_modulator_if #(
  parameter int AMP_W = qam_pkg::AMP_W_DEF
);
  logic                enable;
  logic                elojel_sin;
  logic                elojel_cos;
  logic                symbol_strobe;
  logic signed [AMP_W:0] qam_out;
  logic                qam_valid;

  modport master (
    output enable, elojel_sin, elojel_cos,
    input  symbol_strobe, qam_out, qam_valid
  );

  modport slave (
    input  enable, elojel_sin, elojel_cos,
    output symbol_strobe, qam_out, qam_valid
  );
endinterface

// File: rtl/qam_quarter_sine.sv
// Two-stage sine evaluator: quadrant fold / address decode, then quarter-wave
// LUT read with lower-half negation.
module qam_quarter_sine
  import qam_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP_W  = AMP_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LUT_AW+1:0]       phase,
  output logic signed [AMP_W-1:0] value
);

  localparam int LUT_DEPTH = (1 << LUT_AW) + 1;
  localparam int IDX_W     = LUT_AW + 1;

  // Constant table: pure wiring, so there is no storage to reset.
  logic [AMP_W-2:0] lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam int ENTRY = quarter_sine(k, LUT_AW, AMP_W);
    assign lut[k] = (AMP_W - 1)'(ENTRY);
  end

  quadrant_t         quad;
  logic [LUT_AW-1:0] addr;
  logic [IDX_W-1:0]  idx_next;
  logic [IDX_W-1:0]  idx_q;
  logic              neg_q;
  logic signed [AMP_W-1:0] mag;

  assign quad = quadrant_t'(phase[LUT_AW+1 -: 2]);
  assign addr = phase[LUT_AW-1:0];

  // NOTE: a default before the conditional keeps this purely combinational; a missing else would infer a latch.
  always_comb begin
    idx_next = {1'b0, addr};
    if (quad_mirrors(quad)) idx_next = IDX_W'(1 << LUT_AW) - {1'b0, addr};
  end

  assign mag = signed'({1'b0, lut[idx_q]});

  // NOTE: registers update with <= so every stage samples the pre-edge value of the one before it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      neg_q <= 1'b0;
      value <= '0;
    end else begin
      idx_q <= idx_next;
      neg_q <= quad_negates(quad);
      value <= neg_q ? -mag : mag;
    end
  end

endmodule

// File: rtl/qam_modulator.sv
// QPSK/4-QAM modulator: symbol counter, phase accumulator and sign latch feed a
// 3-stage pipeline producing qam_out = s_sin*sin + s_cos*cos.
module qam_modulator
  import qam_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_AW     = LUT_AW_DEF,
  parameter int AMP_W      = AMP_W_DEF,
  parameter int SYMBOL_LEN = SYMBOL_LEN_DEF,
  parameter int PHASE_INC  = PHASE_INC_DEF
) (
  input  logic            clock,
  input  logic            reset,
  qam_modulator_if.slave  bus
);

  localparam int                 CNT_W    = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SYMBOL_LEN - 1);
  localparam logic [PHASE_W-1:0] STEP     = PHASE_W'(PHASE_INC);
  localparam int                 FOLD_W   = LUT_AW + 2;

  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] phase;
  sign_pair_t         sg;
  logic               strobe;
  logic               symbol_end;

  assign symbol_end = (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      phase  <= '0;
      sg     <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= bus.enable && symbol_end;
      if (bus.enable) begin
        phase <= phase + STEP;
        if (symbol_end) begin
          cnt <= '0;
          sg  <= '{s_sin: bus.elojel_sin, s_cos: bus.elojel_cos};
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Cosine is sine a quarter turn ahead: bump the quadrant bits only.
  logic [FOLD_W-1:0] sin_fold;
  logic [FOLD_W-1:0] cos_fold;

  assign sin_fold = phase[PHASE_W-1 -: FOLD_W];
  assign cos_fold = {sin_fold[FOLD_W-1 -: 2] + 2'd1, sin_fold[LUT_AW-1:0]};

  logic signed [AMP_W-1:0] sin_val;
  logic signed [AMP_W-1:0] cos_val;

  qam_quarter_sine #(.LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_sin (
    .clock (clock),
    .reset (reset),
    .phase (sin_fold),
    .value (sin_val)
  );

  qam_quarter_sine #(.LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_cos (
    .clock (clock),
    .reset (reset),
    .phase (cos_fold),
    .value (cos_val)
  );

  // Signs and the valid flag ride alongside the two evaluator stages so a
  // symbol boundary lands on exactly the sample whose phase opened it.
  sign_pair_t sg_d1;
  sign_pair_t sg_d2;
  logic       vld_d1;
  logic       vld_d2;

  logic signed [AMP_W:0] sin_ext;
  logic signed [AMP_W:0] cos_ext;
  logic signed [AMP_W:0] sin_term;
  logic signed [AMP_W:0] cos_term;
  logic signed [AMP_W:0] sum_q;
  logic                  valid_q;

  assign sin_ext  = {sin_val[AMP_W-1], sin_val};
  assign cos_ext  = {cos_val[AMP_W-1], cos_val};
  assign sin_term = (sg_d2.s_sin == SIGN_NEG) ? -sin_ext : sin_ext;
  assign cos_term = (sg_d2.s_cos == SIGN_NEG) ? -cos_ext : cos_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sg_d1   <= '0;
      sg_d2   <= '0;
      vld_d1  <= 1'b0;
      vld_d2  <= 1'b0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sg_d1   <= sg;
      sg_d2   <= sg_d1;
      vld_d1  <= bus.enable;
      vld_d2  <= vld_d1;
      sum_q   <= sin_term + cos_term;
      valid_q <= vld_d2;
    end
  end

  assign bus.symbol_strobe = strobe;
  assign bus.qam_out       = sum_q;
  assign bus.qam_valid     = valid_q;

endmodule

// File: tb/tb_qam_modulator.sv
// Scoreboarded bench for qam_modulator: a fs/4 instance and a default fs/8
// instance share stimulus and are compared against a real-valued sine model.
module tb_qam_modulator;

  localparam int  SYM    = 16;
  localparam int  AMAX_M = 511;
  localparam real PI     = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  qam_modulator_if #(.AMP_W(10)) bus_a ();
  qam_modulator_if #(.AMP_W(10)) bus_b ();

  qam_modulator #(.PHASE_INC(16384)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  qam_modulator dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    logic valid;
    int   value;
  } exp_t;

  exp_t sbq_a[$];
  exp_t sbq_b[$];

  int          checks    = 0;
  int          errors    = 0;
  int          strobes_a = 0;
  logic [15:0] ph_a;
  logic [15:0] ph_b;
  int          cnt_m;
  logic        ss_m;
  logic        sc_m;

  function automatic int ref_sin(input logic [15:0] ph);
    logic [15:0] trunc;
    real         v;
    trunc = {ph[15:8], 8'h00};
    v = real'(AMAX_M) * $sin(2.0 * PI * real'(trunc) / 65536.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  function automatic int ref_sample(input logic [15:0] ph, input logic ss, input logic sc);
    int s;
    int c;
    s = ref_sin(ph);
    c = ref_sin(ph + 16'h4000);
    return (ss ? -s : s) + (sc ? -c : c);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ph_a  = '0;
    ph_b  = '0;
    cnt_m = 0;
    ss_m  = 1'b0;
    sc_m  = 1'b0;
    sbq_a.delete();
    sbq_b.delete();
    // Two pipeline slots still hold reset contents when the first tuple enters.
    repeat (2) begin
      sbq_a.push_back('{1'b0, 0});
      sbq_b.push_back('{1'b0, 0});
    end
  endtask

  task automatic check_zero(input string when);
    check({when, "_out_a"},    bus_a.qam_out,       0);
    check({when, "_valid_a"},  bus_a.qam_valid,     0);
    check({when, "_strobe_a"}, bus_a.symbol_strobe, 0);
    check({when, "_out_b"},    bus_b.qam_out,       0);
    check({when, "_valid_b"},  bus_b.qam_valid,     0);
    check({when, "_strobe_b"}, bus_b.symbol_strobe, 0);
  endtask

  task automatic score(input int which, input logic obs_valid, input logic signed [31:0] obs_val);
    exp_t e;
    if (which == 0) begin
      if (sbq_a.size() < 3) return;
      e = sbq_a.pop_front();
    end else begin
      if (sbq_b.size() < 3) return;
      e = sbq_b.pop_front();
    end
    check((which == 0) ? "valid_a" : "valid_b", obs_valid, e.valid);
    if (e.valid) check((which == 0) ? "sample_a" : "sample_b", obs_val, e.value);
  endtask

  task automatic tick(input logic en, input logic s, input logic c);
    logic exp_strobe;
    bus_a.enable = en;  bus_a.elojel_sin = s;  bus_a.elojel_cos = c;
    bus_b.enable = en;  bus_b.elojel_sin = s;  bus_b.elojel_cos = c;
    sbq_a.push_back('{en, ref_sample(ph_a, ss_m, sc_m)});
    sbq_b.push_back('{en, ref_sample(ph_b, ss_m, sc_m)});
    exp_strobe = en && (cnt_m == SYM - 1);
    if (en) begin
      ph_a = ph_a + 16'd16384;
      ph_b = ph_b + 16'd8192;
      if (cnt_m == SYM - 1) begin
        cnt_m = 0;
        ss_m  = s;
        sc_m  = c;
      end else begin
        cnt_m++;
      end
    end
    @(posedge clock);
    #1;
    check("strobe_a", bus_a.symbol_strobe, exp_strobe);
    check("strobe_b", bus_b.symbol_strobe, exp_strobe);
    score(0, bus_a.qam_valid, bus_a.qam_out);
    score(1, bus_b.qam_valid, bus_b.qam_out);
    if (bus_a.symbol_strobe) strobes_a++;
  endtask

  initial begin
    int n;
    bus_a.enable = 1'b0;  bus_a.elojel_sin = 1'b0;  bus_a.elojel_cos = 1'b0;
    bus_b.enable = 1'b0;  bus_b.elojel_sin = 1'b0;  bus_b.elojel_cos = 1'b0;

    // Reset held with enable toggling: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      bus_a.enable = i[0];
      bus_b.enable = i[0];
      @(posedge clock);
      #1;
      check_zero("reset_hold");
    end
    reset = 1'b1;
    model_reset();

    // fs/4 carrier, signs {0,0}: 511, 511, -511, -511; first valid 3 clocks in.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);

    // Signs {1,0} take effect on the first sample of the next symbol.
    for (int i = 0; i < 28; i++) tick(1'b1, 1'b1, 1'b0);

    // Enable gaps of 5 cycles stretch the symbol and drop 5 valid samples.
    strobes_a = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 11; i++) tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)  tick(1'b0, 1'b0, 1'b1);
    end
    check("gap_strobe_count", strobes_a, 2);

    // fs/8 instance wraps 0xE000 -> 0x0000 repeatedly against the model.
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0);

    // Reset mid-symbol at cnt 7.
    n = 0;
    while (cnt_m != 7 && n < 40) begin
      tick(1'b1, 1'b1, 1'b1);
      n++;
    end
    check("reach_cnt7", cnt_m, 7);
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clock);
    #1;
    check_zero("reset_mid");
    reset = 1'b1;
    model_reset();
    n = 0;
    do begin
      tick(1'b1, 1'b0, 1'b0);
      n++;
    end while (!bus_a.symbol_strobe && n < 40);
    check("first_strobe_after_reset", n, SYM);

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
